// File: rtl/trace_dispatcher_if.sv
// Trace dispatcher bus: the trace-record input channel from the trace reader,
// the two cache command channels, the broadcast strobes and the statistics
// counters. The dispatcher takes the master side; the trace reader, the caches
// and any observer take the slave side.
interface trace_dispatcher_if #(
  parameter int ADDR_W = 32
);
  // Trace record input channel
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_n;
  logic [ADDR_W-1:0] in_addr;

  // Instruction-cache command channel
  logic              ic_valid;
  logic [3:0]        ic_n;
  logic [ADDR_W-1:0] ic_add;
  logic              ic_busy;

  // Data-cache command channel
  logic              dc_valid;
  logic [3:0]        dc_n;
  logic [ADDR_W-1:0] dc_add;
  logic              dc_busy;

  // Broadcasts and statistics
  logic              clear;
  logic              print;
  logic [31:0]       cmd_cnt;
  logic [31:0]       bad_cnt;

  modport master (
    input  in_valid, in_n, in_addr, ic_busy, dc_busy,
    output in_ready,
    output ic_valid, ic_n, ic_add,
    output dc_valid, dc_n, dc_add,
    output clear, print, cmd_cnt, bad_cnt
  );

  modport slave (
    output in_valid, in_n, in_addr, ic_busy, dc_busy,
    input  in_ready,
    input  ic_valid, ic_n, ic_add,
    input  dc_valid, dc_n, dc_add,
    input  clear, print, cmd_cnt, bad_cnt
  );
endinterface

// File: rtl/trace_dispatcher.sv
// Trace dispatcher: buffers trace records in a small FIFO and issues the head
// record, at most one per cycle, as a registered single-cycle command to the
// I-cache or D-cache, or as a clear/print broadcast once both caches are idle.
// Records with an unknown operation code are dropped and counted.
module trace_dispatcher #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  trace_dispatcher_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Where the head record has to go.
  typedef enum logic [1:0] {
    RT_IC  = 2'd0,
    RT_DC  = 2'd1,
    RT_BC  = 2'd2,
    RT_BAD = 2'd3
  } route_t;

  // RUN dispatches normally; QUIESCE holds a clear/print at the head until
  // both caches are idle in the same cycle.
  typedef enum logic {
    S_RUN     = 1'b0,
    S_QUIESCE = 1'b1
  } state_t;

  // Operation code decode.
  function automatic route_t route_of(input logic [3:0] n);
    route_t r;
    case (n)
      4'd2:                   r = RT_IC;
      4'd0, 4'd1, 4'd3, 4'd4: r = RT_DC;
      4'd8, 4'd9:             r = RT_BC;
      default:                r = RT_BAD;
    endcase
    return r;
  endfunction

  // Statistics counters wrap at 2^32; no saturation.
  function automatic logic [31:0] cnt_inc(input logic [31:0] v);
    return v + 32'd1;
  endfunction

  // FIFO storage and control
  logic [3:0]        mem_n    [DEPTH];
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              up;
  logic              in_ready;
  logic              push;
  logic              pop;
  logic              empty;

  // FSM
  state_t state;
  state_t state_nxt;

  // Head-of-FIFO view (stage p0, combinational)
  logic [3:0]        hd_n_p0;
  logic [ADDR_W-1:0] hd_addr_p0;
  route_t            hd_rt_p0;

  // Dispatch decisions made this cycle
  logic ic_fire;
  logic dc_fire;
  logic clr_fire;
  logic prt_fire;
  logic bad_fire;

  // Registered command outputs (stage p1)
  logic              ic_vld_p1;
  logic [3:0]        ic_n_p1;
  logic [ADDR_W-1:0] ic_add_p1;
  logic              dc_vld_p1;
  logic [3:0]        dc_n_p1;
  logic [ADDR_W-1:0] dc_add_p1;
  logic              clr_p1;
  logic              prt_p1;
  logic [31:0]       cmd_cnt_q;
  logic [31:0]       bad_cnt_q;

  // in_ready is held low during reset and for the cycle in which reset is
  // first seen low; 'up' records that a non-reset edge has occurred. It looks
  // only at the registered occupancy, so a same-cycle pop never frees a slot.
  assign in_ready = up && !rst && (count != CNT_W'(DEPTH));
  assign push     = bus.in_valid && in_ready;
  assign empty    = (count == '0);

  // ---- stage p0: head of FIFO ----
  assign hd_n_p0    = mem_n[rd_ptr];
  assign hd_addr_p0 = mem_addr[rd_ptr];
  assign hd_rt_p0   = route_of(hd_n_p0);

  // Record storage: data only, written on push, never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_n[wr_ptr]    <= bus.in_n;
      mem_addr[wr_ptr] <= bus.in_addr;
    end
  end

  // FIFO pointers and occupancy; reset discards every buffered record.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      up     <= 1'b0;
    end else begin
      up <= 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state register; reset drops any pending QUIESCE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: a broadcast at the head parks the machine in QUIESCE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN: begin
        if (!empty && (hd_rt_p0 == RT_BC)) begin
          state_nxt = S_QUIESCE;
        end
      end
      S_QUIESCE: begin
        if (!bus.ic_busy && !bus.dc_busy) begin
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_RUN;
    endcase
  end

  // FSM outputs: pop the head only when its target can take it; a busy
  // target stalls the whole queue, so records never overtake each other.
  always_comb begin
    pop      = 1'b0;
    ic_fire  = 1'b0;
    dc_fire  = 1'b0;
    clr_fire = 1'b0;
    prt_fire = 1'b0;
    bad_fire = 1'b0;
    case (state)
      S_RUN: begin
        if (!empty) begin
          case (hd_rt_p0)
            RT_IC: begin
              if (!bus.ic_busy) begin
                pop     = 1'b1;
                ic_fire = 1'b1;
              end
            end
            RT_DC: begin
              if (!bus.dc_busy) begin
                pop     = 1'b1;
                dc_fire = 1'b1;
              end
            end
            RT_BAD: begin
              pop      = 1'b1;
              bad_fire = 1'b1;
            end
            default: begin
              // Broadcast: no pop here, the next state is QUIESCE.
            end
          endcase
        end
      end
      S_QUIESCE: begin
        if (!empty && !bus.ic_busy && !bus.dc_busy) begin
          pop = 1'b1;
          if (hd_n_p0 == 4'd8) begin
            clr_fire = 1'b1;
          end else begin
            prt_fire = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // ---- stage p1: registered strobes and statistics ----
  // Strobes last exactly one cycle; counters step once per strobe / drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      ic_vld_p1 <= 1'b0;
      dc_vld_p1 <= 1'b0;
      clr_p1    <= 1'b0;
      prt_p1    <= 1'b0;
      cmd_cnt_q <= '0;
      bad_cnt_q <= '0;
    end else begin
      ic_vld_p1 <= ic_fire;
      dc_vld_p1 <= dc_fire;
      clr_p1    <= clr_fire;
      prt_p1    <= prt_fire;
      if (ic_fire || dc_fire || clr_fire || prt_fire) begin
        cmd_cnt_q <= cnt_inc(cmd_cnt_q);
      end
      if (bad_fire) begin
        bad_cnt_q <= cnt_inc(bad_cnt_q);
      end
    end
  end

  // Command payload registers: load with their strobe and hold otherwise;
  // cleared by reset so the caches never see stale payloads after restart.
  always_ff @(posedge clk) begin
    if (rst) begin
      ic_n_p1   <= '0;
      ic_add_p1 <= '0;
      dc_n_p1   <= '0;
      dc_add_p1 <= '0;
    end else begin
      if (ic_fire) begin
        ic_n_p1   <= hd_n_p0;
        ic_add_p1 <= hd_addr_p0;
      end
      if (dc_fire) begin
        dc_n_p1   <= hd_n_p0;
        dc_add_p1 <= hd_addr_p0;
      end
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.ic_valid = ic_vld_p1;
  assign bus.ic_n     = ic_n_p1;
  assign bus.ic_add   = ic_add_p1;
  assign bus.dc_valid = dc_vld_p1;
  assign bus.dc_n     = dc_n_p1;
  assign bus.dc_add   = dc_add_p1;
  assign bus.clear    = clr_p1;
  assign bus.print    = prt_p1;
  assign bus.cmd_cnt  = cmd_cnt_q;
  assign bus.bad_cnt  = bad_cnt_q;

endmodule

// File: tb/tb_trace_dispatcher.sv
// Testbench for trace_dispatcher: reset state, a table of single-record
// routing vectors, hand-written multi-cycle sequences, and a randomized run
// compared cycle by cycle against a queue-based reference model.
module tb_trace_dispatcher;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  trace_dispatcher_if #(.ADDR_W(ADDR_W)) bus ();

  trace_dispatcher #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0]  n;
    logic [31:0] addr;
  } rec_t;

  rec_t        mq[$];
  bit          m_quiesce = 1'b0;
  bit          m_up      = 1'b0;
  logic        m_ic_v    = 1'b0;
  logic [3:0]  m_ic_n    = '0;
  logic [31:0] m_ic_add  = '0;
  logic        m_dc_v    = 1'b0;
  logic [3:0]  m_dc_n    = '0;
  logic [31:0] m_dc_add  = '0;
  logic        m_clr     = 1'b0;
  logic        m_prt     = 1'b0;
  logic [31:0] m_cmd     = '0;
  logic [31:0] m_bad     = '0;

  // Observed strobe events
  int          ev[$];
  logic [31:0] ev_addr[$];
  int          ev_cyc[$];

  typedef struct {
    logic [3:0]  n;
    logic [31:0] addr;
    int ic;
    int dc;
    int clr;
    int prt;
    int bad;
  } vec_t;

  vec_t tbl [11];
  int   nsel [10] = '{0, 1, 2, 3, 4, 2, 8, 9, 5, 14};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One model step per rising edge, from the rules for the trace dispatcher.
  task automatic model_step();
    bit   can_push;
    rec_t h;
    rec_t r;
    can_push = m_up && !rst && (mq.size() < DEPTH);
    if (rst) begin
      mq.delete();
      m_quiesce = 1'b0;
      m_up      = 1'b0;
      m_ic_v    = 1'b0;
      m_dc_v    = 1'b0;
      m_clr     = 1'b0;
      m_prt     = 1'b0;
      m_ic_n    = '0;
      m_ic_add  = '0;
      m_dc_n    = '0;
      m_dc_add  = '0;
      m_cmd     = '0;
      m_bad     = '0;
    end else begin
      m_ic_v = 1'b0;
      m_dc_v = 1'b0;
      m_clr  = 1'b0;
      m_prt  = 1'b0;
      if (mq.size() > 0) begin
        h = mq[0];
        if (h.n == 4'd8 || h.n == 4'd9) begin
          if (!m_quiesce) begin
            m_quiesce = 1'b1;
          end else if (!bus.ic_busy && !bus.dc_busy) begin
            void'(mq.pop_front());
            if (h.n == 4'd8) m_clr = 1'b1;
            else             m_prt = 1'b1;
            m_cmd     = m_cmd + 32'd1;
            m_quiesce = 1'b0;
          end
        end else if (h.n == 4'd2) begin
          if (!bus.ic_busy) begin
            void'(mq.pop_front());
            m_ic_v   = 1'b1;
            m_ic_n   = h.n;
            m_ic_add = h.addr;
            m_cmd    = m_cmd + 32'd1;
          end
        end else if (h.n == 4'd0 || h.n == 4'd1 || h.n == 4'd3 || h.n == 4'd4) begin
          if (!bus.dc_busy) begin
            void'(mq.pop_front());
            m_dc_v   = 1'b1;
            m_dc_n   = h.n;
            m_dc_add = h.addr;
            m_cmd    = m_cmd + 32'd1;
          end
        end else begin
          void'(mq.pop_front());
          m_bad = m_bad + 32'd1;
        end
      end
      if (bus.in_valid && can_push) begin
        r.n    = bus.in_n;
        r.addr = bus.in_addr;
        mq.push_back(r);
      end
      m_up = 1'b1;
    end
  endtask

  task automatic compare_model();
    chk("m_in_ready", 64'(bus.in_ready), 64'(m_up && !rst && (mq.size() < DEPTH)));
    chk("m_ic_valid", 64'(bus.ic_valid), 64'(m_ic_v));
    chk("m_ic_n",     64'(bus.ic_n),     64'(m_ic_n));
    chk("m_ic_add",   64'(bus.ic_add),   64'(m_ic_add));
    chk("m_dc_valid", 64'(bus.dc_valid), 64'(m_dc_v));
    chk("m_dc_n",     64'(bus.dc_n),     64'(m_dc_n));
    chk("m_dc_add",   64'(bus.dc_add),   64'(m_dc_add));
    chk("m_clear",    64'(bus.clear),    64'(m_clr));
    chk("m_print",    64'(bus.print),    64'(m_prt));
    chk("m_cmd_cnt",  64'(bus.cmd_cnt),  64'(m_cmd));
    chk("m_bad_cnt",  64'(bus.bad_cnt),  64'(m_bad));
  endtask

  // Advance one clock: model at the rising edge, observe at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    if (chk_en) compare_model();
  endtask

  task automatic observe();
    chk("one_strobe", 64'($countones({bus.ic_valid, bus.dc_valid, bus.clear, bus.print}) <= 1), 64'(1));
    if (bus.ic_valid) begin ev.push_back(1); ev_addr.push_back(bus.ic_add); ev_cyc.push_back(cyc); end
    if (bus.dc_valid) begin ev.push_back(2); ev_addr.push_back(bus.dc_add); ev_cyc.push_back(cyc); end
    if (bus.clear)    begin ev.push_back(3); ev_addr.push_back(32'h0);      ev_cyc.push_back(cyc); end
    if (bus.print)    begin ev.push_back(4); ev_addr.push_back(32'h0);      ev_cyc.push_back(cyc); end
  endtask

  function automatic int count_ev(input int code);
    int c = 0;
    foreach (ev[i]) if (ev[i] == code) c++;
    return c;
  endfunction

  task automatic clear_ev();
    ev.delete();
    ev_addr.delete();
    ev_cyc.delete();
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic drive_rec(input logic [3:0] n, input logic [31:0] addr);
    bus.in_valid = 1'b1;
    bus.in_n     = n;
    bus.in_addr  = addr;
  endtask

  initial begin
    int rel;
    int clr_c;

    tbl[0]  = '{4'd0,  32'h1000_0000, 0, 1, 0, 0, 0};
    tbl[1]  = '{4'd1,  32'h2000_0001, 0, 1, 0, 0, 0};
    tbl[2]  = '{4'd2,  32'h3000_0002, 1, 0, 0, 0, 0};
    tbl[3]  = '{4'd3,  32'hDEAD_BEEF, 0, 1, 0, 0, 0};
    tbl[4]  = '{4'd4,  32'hFFFF_FFFF, 0, 1, 0, 0, 0};
    tbl[5]  = '{4'd5,  32'h0000_0005, 0, 0, 0, 0, 1};
    tbl[6]  = '{4'd7,  32'h0000_0007, 0, 0, 0, 0, 1};
    tbl[7]  = '{4'd8,  32'h0000_0008, 0, 0, 1, 0, 0};
    tbl[8]  = '{4'd9,  32'h0000_0009, 0, 0, 0, 1, 0};
    tbl[9]  = '{4'd10, 32'h0000_000A, 0, 0, 0, 0, 1};
    tbl[10] = '{4'd15, 32'h8000_0000, 0, 0, 0, 0, 1};

    bus.in_valid = 1'b0;
    bus.in_n     = '0;
    bus.in_addr  = '0;
    bus.ic_busy  = 1'b0;
    bus.dc_busy  = 1'b0;

    // Reset state, sampled with rst still high
    tick();
    tick();
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    chk("rst_strobes",  64'({bus.ic_valid, bus.dc_valid, bus.clear, bus.print}), 64'(0));
    chk("rst_ic_data",  64'({bus.ic_n, bus.ic_add}), 64'(0));
    chk("rst_dc_data",  64'({bus.dc_n, bus.dc_add}), 64'(0));
    chk("rst_cmd_cnt",  64'(bus.cmd_cnt), 64'(0));
    chk("rst_bad_cnt",  64'(bus.bad_cnt), 64'(0));
    rst = 1'b0;
    chk("ready_before_low_sampled", 64'(bus.in_ready), 64'(0));
    tick();
    chk("ready_after_rst", 64'(bus.in_ready), 64'(1));

    // Minimum latency to the I-cache
    drive_rec(4'd2, 32'h0000_1234);
    tick();
    bus.in_valid = 1'b0;
    chk("lat_ic_early", 64'(bus.ic_valid), 64'(0));
    tick();
    chk("lat_ic_valid", 64'(bus.ic_valid), 64'(1));
    chk("lat_ic_add",   64'(bus.ic_add),   64'(32'h0000_1234));
    chk("lat_ic_n",     64'(bus.ic_n),     64'(2));
    chk("lat_dc_valid", 64'(bus.dc_valid), 64'(0));
    chk("lat_cmd_cnt",  64'(bus.cmd_cnt),  64'(1));
    tick();
    chk("lat_ic_single", 64'(bus.ic_valid), 64'(0));
    chk("lat_ic_hold",   64'(bus.ic_add),   64'(32'h0000_1234));

    // Fill to DEPTH behind a busy D-cache, then drain in order
    bus.dc_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      drive_rec(4'd0, 32'h100 + 32'(i));
      tick();
    end
    bus.in_valid = 1'b0;
    chk("full_in_ready", 64'(bus.in_ready), 64'(0));
    chk("full_no_dc",    64'(bus.dc_valid), 64'(0));
    bus.dc_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      chk("drain_dc_valid", 64'(bus.dc_valid), 64'(1));
      chk("drain_dc_add",   64'(bus.dc_add),   64'(32'h100 + 32'(i)));
      if (i == 0) chk("drain_ready_back", 64'(bus.in_ready), 64'(1));
    end
    tick();
    chk("drain_done",    64'(bus.dc_valid), 64'(0));
    chk("drain_cmd_cnt", 64'(bus.cmd_cnt),  64'(5));

    // Clear waits for both caches idle, no reordering behind it
    do_reset();
    clear_ev();
    bus.ic_busy = 1'b1;
    drive_rec(4'd1, 32'hA); tick(); observe();
    drive_rec(4'd8, 32'h0); tick(); observe();
    drive_rec(4'd2, 32'hB); tick(); observe();
    bus.in_valid = 1'b0;
    rel = 0;
    for (int k = 0; k < 12; k++) begin
      if (k == 2) begin
        bus.ic_busy = 1'b0;
        rel = cyc;
      end
      tick();
      observe();
    end
    chk("q_ev_count",  64'(ev.size()), 64'(3));
    chk("q_ev0_dc",    64'(ev[0]), 64'(2));
    chk("q_ev0_addr",  64'(ev_addr[0]), 64'(32'hA));
    chk("q_ev1_clear", 64'(ev[1]), 64'(3));
    chk("q_ev2_ic",    64'(ev[2]), 64'(1));
    chk("q_ev2_addr",  64'(ev_addr[2]), 64'(32'hB));
    clr_c = ev_cyc[1];
    chk("q_clear_after_release", 64'(clr_c > rel), 64'(1));
    chk("q_cmd_cnt",   64'(bus.cmd_cnt), 64'(3));

    // Illegal code then print
    do_reset();
    clear_ev();
    drive_rec(4'd5, 32'h55); tick(); observe();
    drive_rec(4'd9, 32'h99); tick(); observe();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      observe();
    end
    chk("bp_no_cache",  64'(count_ev(1) + count_ev(2) + count_ev(3)), 64'(0));
    chk("bp_print_one", 64'(count_ev(4)), 64'(1));
    chk("bp_bad_cnt",   64'(bus.bad_cnt), 64'(1));
    chk("bp_cmd_cnt",   64'(bus.cmd_cnt), 64'(1));

    // Reset mid-operation with a pending QUIESCE and buffered records
    do_reset();
    drive_rec(4'd2, 32'h1); tick();
    drive_rec(4'd6, 32'h2); tick();
    bus.dc_busy = 1'b1;
    drive_rec(4'd8, 32'h3); tick();
    drive_rec(4'd0, 32'h4); tick();
    drive_rec(4'd0, 32'h5); tick();
    bus.in_valid = 1'b0;
    tick();
    chk("mr_cmd_before", 64'(bus.cmd_cnt), 64'(1));
    chk("mr_bad_before", 64'(bus.bad_cnt), 64'(1));
    rst = 1'b1;
    tick();
    chk("mr_cmd_cleared", 64'(bus.cmd_cnt), 64'(0));
    chk("mr_bad_cleared", 64'(bus.bad_cnt), 64'(0));
    chk("mr_ready_in_rst", 64'(bus.in_ready), 64'(0));
    rst = 1'b0;
    bus.dc_busy = 1'b0;
    chk("mr_ready_rst_falling", 64'(bus.in_ready), 64'(0));
    clear_ev();
    tick();
    observe();
    chk("mr_ready_back", 64'(bus.in_ready), 64'(1));
    for (int k = 0; k < 6; k++) begin
      tick();
      observe();
    end
    chk("mr_no_strobes", 64'(ev.size()), 64'(0));
    chk("mr_cmd_zero",   64'(bus.cmd_cnt), 64'(0));

    // Routing table, one record at a time from an idle dispatcher
    for (int t = 0; t < 11; t++) begin
      do_reset();
      clear_ev();
      drive_rec(tbl[t].n, tbl[t].addr);
      tick();
      observe();
      bus.in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
        tick();
        observe();
      end
      chk("tbl_ic_cnt",  64'(count_ev(1)), 64'(tbl[t].ic));
      chk("tbl_dc_cnt",  64'(count_ev(2)), 64'(tbl[t].dc));
      chk("tbl_clr_cnt", 64'(count_ev(3)), 64'(tbl[t].clr));
      chk("tbl_prt_cnt", 64'(count_ev(4)), 64'(tbl[t].prt));
      chk("tbl_cmd_cnt", 64'(bus.cmd_cnt), 64'(tbl[t].ic + tbl[t].dc + tbl[t].clr + tbl[t].prt));
      chk("tbl_bad_cnt", 64'(bus.bad_cnt), 64'(tbl[t].bad));
      if (tbl[t].ic == 1) begin
        chk("tbl_ic_n",   64'(bus.ic_n),   64'(tbl[t].n));
        chk("tbl_ic_add", 64'(bus.ic_add), 64'(tbl[t].addr));
      end else begin
        chk("tbl_ic_add_held", 64'(bus.ic_add), 64'(0));
      end
      if (tbl[t].dc == 1) begin
        chk("tbl_dc_n",   64'(bus.dc_n),   64'(tbl[t].n));
        chk("tbl_dc_add", 64'(bus.dc_add), 64'(tbl[t].addr));
      end else begin
        chk("tbl_dc_add_held", 64'(bus.dc_add), 64'(0));
      end
    end

    // Randomized run against the reference model
    do_reset();
    chk_en = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      bus.in_valid = ($urandom_range(0, 9) < 7);
      bus.in_n     = 4'(nsel[$urandom_range(0, 9)]);
      bus.in_addr  = $urandom();
      bus.ic_busy  = ($urandom_range(0, 3) == 0);
      bus.dc_busy  = ($urandom_range(0, 3) == 0);
      rst          = ($urandom_range(0, 199) == 0);
      tick();
    end
    chk_en       = 1'b0;
    rst          = 1'b0;
    bus.ic_busy  = 1'b0;
    bus.dc_busy  = 1'b0;
    bus.in_valid = 1'b0;

    // Command counter wraps at 2^32
    do_reset();
    force dut.cmd_cnt_q = 32'hFFFF_FFFF;
    tick();
    release dut.cmd_cnt_q;
    chk("wrap_preload", 64'(bus.cmd_cnt), 64'(32'hFFFF_FFFF));
    drive_rec(4'd3, 32'h77);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("wrap_dc_valid", 64'(bus.dc_valid), 64'(1));
    chk("wrap_cmd_cnt",  64'(bus.cmd_cnt),  64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
